// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner ids and priority-mode encodings for the memory port arbiter
package mem_arb_pkg;
  localparam logic OWNER_C = 1'b0;
  localparam logic OWNER_D = 1'b1;
  localparam int PRIO_RR = 0;
  localparam int PRIO_FIXED = 1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select from requests, lock state and round-robin history
module mem_arb_pick import mem_arb_pkg::*; #(
  parameter int PRIO_MODE = PRIO_RR,
  parameter int MAX_HOLD = 8
) (
  input  logic       c_req,
  input  logic       d_req,
  input  logic       locked,
  input  logic       last_owner,
  input  logic [7:0] hold_cnt,
  output logic       valid,
  output logic       winner,
  output logic       force_rel
);
  logic own_req, oth_req, keep;
  always_comb begin
    own_req = last_owner ? d_req : c_req;
    oth_req = last_owner ? c_req : d_req;
    force_rel = locked && own_req && oth_req && hold_cnt == 8'(MAX_HOLD);
    keep = locked && own_req && !force_rel;
    valid = c_req || d_req;
    winner = keep ? last_owner :
             force_rel ? !last_owner :
             (c_req && d_req) ? (PRIO_MODE == PRIO_FIXED ? OWNER_C : !last_owner) :
             d_req;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between the CPU and the debug loader
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int PRIO_MODE = PRIO_RR,
  parameter int MAX_HOLD = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic              c_lock,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic              owner,
  output logic              locked
);
  logic last_owner, lock_q, c_rv, d_rv;
  logic [7:0] hold_cnt;
  logic pick_valid, winner, force_rel, gnt, w_we, w_lock, oth_req;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  mem_arb_pick #(.PRIO_MODE(PRIO_MODE), .MAX_HOLD(MAX_HOLD)) u_pick (
    .c_req(c_req),
    .d_req(d_req),
    .locked(lock_q),
    .last_owner(last_owner),
    .hold_cnt(hold_cnt),
    .valid(pick_valid),
    .winner(winner),
    .force_rel(force_rel)
  );
  always_comb begin
    gnt = pick_valid && !reset;
    w_we = winner ? d_we : c_we;
    w_lock = winner ? d_lock : c_lock;
    w_addr = winner ? d_addr : c_addr;
    w_data = winner ? d_wdata : c_wdata;
    oth_req = winner ? c_req : d_req;
    c_gnt = gnt && winner == OWNER_C;
    d_gnt = gnt && winner == OWNER_D;
    mem_addr = gnt ? w_addr : '0;
    mem_data = gnt ? w_data : '0;
    mem_wren = gnt && w_we;
    mem_rden = gnt && !w_we;
    // masking with reset kills a read return that lands in a reset cycle
    c_rvalid = c_rv && !reset;
    d_rvalid = d_rv && !reset;
    c_rdata = mem_q;
    d_rdata = mem_q;
    owner = last_owner;
    locked = lock_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      last_owner <= OWNER_D;
      lock_q <= 1'b0;
      hold_cnt <= 8'd0;
      c_rv <= 1'b0;
      d_rv <= 1'b0;
    end else begin
      c_rv <= c_gnt && !c_we;
      d_rv <= d_gnt && !d_we;
      if (gnt) begin
        last_owner <= winner;
        lock_q <= w_lock && !force_rel;
        // counts grants handed out while the other port is kept waiting
        hold_cnt <= (w_lock && oth_req && !force_rel) ?
                    (winner == last_owner ? hold_cnt : 8'd0) + 8'd1 : 8'd0;
      end else begin
        hold_cnt <= 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plan plus random traffic on a round-robin and a fixed-priority arbiter
module tb_mem_port_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic rq [2][2], we [2][2], lk [2][2];
  logic [7:0] ad [2][2], wd [2][2];
  wire [1:0] cg, dg, cv, dv, wren, rden, own, lkd;
  wire [7:0] cr [2], dr [2], maddr [2], mdata [2];
  logic [7:0] mq [2];
  logic [7:0] tmem [2][256];
  bit [255:0] seen [2];

  int n_chk = 0, n_err = 0;
  int m_last [2], m_lk [2], m_hold [2];
  bit m_rv [2][2];
  logic [7:0] m_rd [2];
  logic [7:0] ref_mem [2][256];
  bit gl [2][2];

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_MODE(0), .MAX_HOLD(8)) dut_rr (
    .clock(clock), .reset(reset),
    .c_req(rq[0][0]), .c_we(we[0][0]), .c_addr(ad[0][0]), .c_wdata(wd[0][0]), .c_lock(lk[0][0]),
    .c_gnt(cg[0]), .c_rvalid(cv[0]), .c_rdata(cr[0]),
    .d_req(rq[0][1]), .d_we(we[0][1]), .d_addr(ad[0][1]), .d_wdata(wd[0][1]), .d_lock(lk[0][1]),
    .d_gnt(dg[0]), .d_rvalid(dv[0]), .d_rdata(dr[0]),
    .mem_addr(maddr[0]), .mem_data(mdata[0]), .mem_wren(wren[0]), .mem_rden(rden[0]), .mem_q(mq[0]),
    .owner(own[0]), .locked(lkd[0])
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_MODE(1), .MAX_HOLD(3)) dut_fx (
    .clock(clock), .reset(reset),
    .c_req(rq[1][0]), .c_we(we[1][0]), .c_addr(ad[1][0]), .c_wdata(wd[1][0]), .c_lock(lk[1][0]),
    .c_gnt(cg[1]), .c_rvalid(cv[1]), .c_rdata(cr[1]),
    .d_req(rq[1][1]), .d_we(we[1][1]), .d_addr(ad[1][1]), .d_wdata(wd[1][1]), .d_lock(lk[1][1]),
    .d_gnt(dg[1]), .d_rvalid(dv[1]), .d_rdata(dr[1]),
    .mem_addr(maddr[1]), .mem_data(mdata[1]), .mem_wren(wren[1]), .mem_rden(rden[1]), .mem_q(mq[1]),
    .owner(own[1]), .locked(lkd[1])
  );

  // memory: unwritten locations read back as addr ^ 0xB5 (so 0x10 holds 0xA5)
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (wren[i]) begin
        tmem[i][maddr[i]] <= mdata[i];
        seen[i][maddr[i]] <= 1'b1;
      end
      if (rden[i]) mq[i] <= seen[i][maddr[i]] ? tmem[i][maddr[i]] : maddr[i] ^ 8'hB5;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int maxh(input int i);
    return i ? 3 : 8;
  endfunction

  // reference model: applies the arbitration rules to the current inputs, checks, then advances
  task automatic model_cycle();
    for (int i = 0; i < 2; i++) begin
      int w, o;
      bit f, ewr, erd;
      logic [7:0] ea, ed;
      string s;
      s = $sformatf("u%0d", i);
      w = -1; f = 0; o = m_last[i];
      if (!reset) begin
        if (m_lk[i] != 0 && rq[i][o]) begin
          if (m_hold[i] == maxh(i) && rq[i][1-o]) begin w = 1 - o; f = 1; end
          else w = o;
        end else if (rq[i][0] && rq[i][1]) w = (i == 1) ? 0 : 1 - o;
        else if (rq[i][0]) w = 0;
        else if (rq[i][1]) w = 1;
      end
      ewr = 0; erd = 0; ea = 8'h00; ed = 8'h00;
      if (w >= 0) begin
        ewr = we[i][w]; erd = !we[i][w]; ea = ad[i][w]; ed = wd[i][w];
      end
      check({s, "_cgnt"}, cg[i], w == 0);
      check({s, "_dgnt"}, dg[i], w == 1);
      check({s, "_wren"}, wren[i], ewr);
      check({s, "_rden"}, rden[i], erd);
      check({s, "_maddr"}, maddr[i], ea);
      check({s, "_mdata"}, mdata[i], ed);
      check({s, "_owner"}, own[i], m_last[i]);
      check({s, "_locked"}, lkd[i], m_lk[i]);
      check({s, "_crv"}, cv[i], m_rv[i][0] && !reset);
      check({s, "_drv"}, dv[i], m_rv[i][1] && !reset);
      if (m_rv[i][0] && !reset) check({s, "_crdata"}, cr[i], m_rd[i]);
      if (m_rv[i][1] && !reset) check({s, "_drdata"}, dr[i], m_rd[i]);
      if (reset) begin
        m_last[i] = 1; m_lk[i] = 0; m_hold[i] = 0;
        m_rv[i][0] = 0; m_rv[i][1] = 0;
      end else begin
        m_rv[i][0] = (w == 0) && erd;
        m_rv[i][1] = (w == 1) && erd;
        if (w >= 0) begin
          if (erd) m_rd[i] = ref_mem[i][ea];
          else ref_mem[i][ea] = ed;
          m_hold[i] = (lk[i][w] && rq[i][1-w] && !f) ? ((w == o ? m_hold[i] : 0) + 1) : 0;
          m_lk[i] = (lk[i][w] && !f) ? 1 : 0;
          m_last[i] = w;
        end else m_hold[i] = 0;
      end
      gl[i][0] = (w == 0);
      gl[i][1] = (w == 1);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    model_cycle();
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic setp(input int i, input int p, input bit r, input bit w_, input logic [7:0] a,
                      input logic [7:0] d, input bit l);
    rq[i][p] = r; we[i][p] = w_; ad[i][p] = a; wd[i][p] = d; lk[i][p] = l;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) setp(i, p, 0, 0, 8'h00, 8'h00, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) ref_mem[i][a] = 8'(a) ^ 8'hB5;
      m_last[i] = 1; m_lk[i] = 0; m_hold[i] = 0; m_rd[i] = 8'h00;
      m_rv[i][0] = 0; m_rv[i][1] = 0;
    end
    idle_all();
    cyc();
    check("rst_owner", own[0], 1);
    check("rst_locked", lkd[0], 0);
    check("rst_gnt", cg[0] | dg[0], 0);
    adv(); cyc(); adv();
    reset = 1'b0;
    // plan 1: C read of 0x10
    setp(0, 0, 1, 0, 8'h10, 8'h00, 0);
    cyc();
    check("t1_cgnt", cg[0], 1);
    adv();
    setp(0, 0, 0, 0, 8'h00, 8'h00, 0);
    cyc();
    check("t1_cvalid", cv[0], 1);
    check("t1_rdata", cr[0], 8'hA5);
    check("t1_dvalid", dv[0], 0);
    adv();
    // plans 2 and 4: both ports request continuously
    reset = 1'b1; cyc(); adv(); reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      setp(i, 0, 1, 0, 8'h01, 8'h00, 0);
      setp(i, 1, 1, 0, 8'h02, 8'h00, 0);
    end
    for (int k = 0; k < 6; k++) begin
      cyc();
      check($sformatf("t2_cgnt%0d", k), cg[0], k % 2 == 0);
      check($sformatf("t2_dgnt%0d", k), dg[0], k % 2 == 1);
      if (k < 4) begin
        check($sformatf("t4_cgnt%0d", k), cg[1], 1);
        check($sformatf("t4_dgnt%0d", k), dg[1], 0);
      end
      adv();
    end
    idle_all(); cyc(); adv();
    // plan 3: D locked burst against a waiting C
    reset = 1'b1; cyc(); adv(); reset = 1'b0;
    setp(0, 0, 1, 0, 8'h20, 8'h00, 0);
    cyc(); adv();
    n = 0;
    setp(0, 1, 1, 1, 8'h20, 8'hD0, 1);
    for (int k = 0; k < 12; k++) begin
      cyc();
      check($sformatf("t3_dgnt%0d", k), dg[0], k != 8);
      if (k >= 1 && k <= 8) check($sformatf("t3_locked%0d", k), lkd[0], 1);
      if (k == 9) check("t3_unlocked", lkd[0], 0);
      adv();
      if (gl[0][1]) begin
        n++;
        setp(0, 1, 1, 1, 8'h20 + 8'(n), 8'hD0 + 8'(n), 1);
      end
    end
    idle_all(); cyc(); adv();
    // plan 5: reset right after a granted locked read
    setp(0, 0, 1, 0, 8'h07, 8'h00, 1);
    cyc();
    check("t5_cgnt", cg[0], 1);
    adv();
    idle_all();
    reset = 1'b1;
    cyc();
    check("t5_cvalid", cv[0], 0);
    adv();
    reset = 1'b0;
    cyc();
    check("t5_owner", own[0], 1);
    check("t5_locked", lkd[0], 0);
    adv();
    // plan 6: D write then C read of the same address
    setp(0, 1, 1, 1, 8'h05, 8'h3C, 0);
    cyc();
    check("t6_dgnt", dg[0], 1);
    adv();
    setp(0, 1, 0, 0, 8'h00, 8'h00, 0);
    setp(0, 0, 1, 0, 8'h05, 8'h00, 0);
    cyc();
    check("t6_cgnt", cg[0], 1);
    adv();
    idle_all();
    cyc();
    check("t6_cvalid", cv[0], 1);
    check("t6_rdata", cr[0], 8'h3C);
    adv();
    // random traffic; a port only changes its request after a grant or while idle
    for (int t = 0; t < 3000; t++) begin
      reset = ($urandom_range(149) == 0);
      cyc();
      adv();
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++)
          if (gl[i][p] || !rq[i][p])
            setp(i, p, $urandom_range(3) != 0, 1'($urandom_range(1)), 8'($urandom_range(15)),
                 8'($urandom), $urandom_range(2) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Single-cycle arbiter that shares the processor's single-port synchronous data/instruction memory between two requesters. Port C is the multicycle CPU (fetch, load, store). Port D is the debug/program loader driven from board switches.
- Each cycle, grants at most one access: round-robin or fixed priority, with an optional lock for back-to-back bursts.
- Returns read data one cycle later, tagged by port.
- Sits between the CPU/loader and the memory instance; its state is exported to LEDs for board debug.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, C always wins
MAX_HOLD, 8, consecutive locked grants allowed while the other port waits (range 1..255)

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
c_req  in  1  CPU access request
c_we  in  1  CPU write (1) / read (0)
c_addr  in  ADDR_W  CPU address
c_wdata  in  DATA_W  CPU write data
c_lock  in  1  CPU asks to keep ownership after this grant
c_gnt  out  1  CPU access accepted this cycle
c_rvalid  out  1  CPU read data valid
c_rdata  out  DATA_W  CPU read data
d_req, d_we, d_addr, d_wdata, d_lock, d_gnt, d_rvalid, d_rdata  same as c_*, for the debug/loader port
mem_addr  out  ADDR_W  memory address
mem_data  out  DATA_W  memory write data
mem_wren  out  1  memory write enable
mem_rden  out  1  memory read enable
mem_q  in  DATA_W  memory read data, registered inside memory, valid 1 cycle after mem_rden
owner  out  1  last granted port (0 = C, 1 = D)
locked  out  1  ownership lock active

Behaviour:
- Reset is synchronous, active-high on clock. It sets:
  - last_owner = 1 (D), so C wins the first tie
  - locked = 0, hold_cnt = 0
  - rvalid pipeline = 0
  - c_gnt, d_gnt, mem_wren, mem_rden = 0 during reset
- Grant is combinational from requests plus registered state. Req and gnt in the same cycle means the access is performed that cycle. A requester holds req, we, addr and wdata stable until it sees gnt.
- Winner selection, in order:
  - locked = 1 and owner still requesting: owner wins, unless hold_cnt == MAX_HOLD and the other port requests; then the other port wins and the lock is cleared.
  - Only one req: that port wins.
  - Both req, PRIO_MODE = 0: the port != last_owner wins.
  - Both req, PRIO_MODE = 1: C wins.
  - No req: no grant; mem_wren = mem_rden = 0, mem_addr = mem_data = 0.
- Memory drive: mem_addr/mem_data come from the winner; mem_wren = winner we; mem_rden = winner !we.
- Read return: a granted read by port X sets X_rvalid = 1 in the next cycle, for exactly 1 cycle. X_rdata = mem_q (passthrough). The other port's rdata is don't-care; drive mem_q on both.
- Writes produce no rvalid.
- Register update on each grant:
  - last_owner = winner
  - locked = winner's lock input, and 0 if forced release
  - hold_cnt: increments while locked and the other port is waiting; cleared on owner change, on lock drop, or when the other port is not requesting.
- Owner drops req while locked: the lock is released the same cycle with no idle bubble. The other port may win that cycle.
- A locked owner's lock input is only sampled on its grants. With no grant, locked is unchanged.
- MAX_HOLD saturation: the forced release gives exactly one grant to the waiting port. The original owner may re-lock on its next grant.
- Reset while a read is in flight: rvalid is suppressed the following cycle.
- Never assert c_gnt and d_gnt together.

Decomposition:
- Shared package mem_arb_pkg:
  - OWNER_C = 0, OWNER_D = 1
  - PRIO_RR = 0, PRIO_FIXED = 1
- Sub-module mem_arb_pick: pure combinational winner select from req, lock state, last_owner, hold_cnt and PRIO_MODE.
- The top-level holds the registers, the memory mux and the rvalid pipeline.

Test Plan:
1. Reset, then C read addr 0x10 with memory holding 0xA5 → c_gnt = 1 cycle 0; c_rvalid = 1, c_rdata = 0xA5 cycle 1; d_rvalid = 0.
2. C and D both request continuously, no lock, PRIO_MODE = 0 → grants alternate C, D, C, D; the first grant goes to C.
3. D locked burst writing 0x20..0x2F while C requests, MAX_HOLD = 8 → D gets 8 consecutive grants with locked = 1, then C gets 1 grant, then D resumes.
4. PRIO_MODE = 1, both request for 4 cycles → c_gnt = 1 all 4 cycles; d_gnt = 0.
5. C read granted and reset asserted the next cycle → c_rvalid stays 0; owner = 1, locked = 0 after reset.
6. D writes 0x3C to 0x05, then C reads 0x05 in the next cycle → c_rdata = 0x3C with c_rvalid one cycle after c_gnt.
